// File: rtl/imem_loader.sv
// Instruction-cache fill engine: packs a byte stream into 39-bit words, writes them
// to consecutive cache addresses from 0, and holds the core in reset while loading.
module imem_loader #(
  parameter int IW    = 39,
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Start,
  input  logic [6:0]    Word_Count,
  input  logic          Byte_Valid,
  input  logic [7:0]    Byte_Data,
  output logic          Byte_Ready,
  output logic          Wr_En,
  output logic [AW-1:0] Wr_Addr,
  output logic [IW-1:0] Wr_Data,
  output logic          Core_Rst_N,
  output logic          Busy,
  output logic          Done,
  output logic          Err
);

  localparam logic [6:0] MAX_WORDS = 7'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

  state_t        state, state_nx;
  logic [2:0]    byte_idx, byte_idx_nx;
  logic [31:0]   buf_q, buf_nx;
  logic [AW-1:0] addr, addr_nx;
  logic [6:0]    cnt, cnt_nx;
  logic [6:0]    word_cnt, word_cnt_nx;
  logic [6:0]    cnt_clamped;

  logic          ready_nx, wr_en_nx, core_rst_n_nx, busy_nx, done_nx, err_nx;
  logic [AW-1:0] wr_addr_nx;
  logic [IW-1:0] wr_data_nx;

  assign cnt_clamped = (Word_Count > MAX_WORDS) ? MAX_WORDS : Word_Count;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= S_IDLE;
      byte_idx   <= '0;
      buf_q      <= '0;
      addr       <= '0;
      cnt        <= '0;
      word_cnt   <= '0;
      Byte_Ready <= 1'b0;
      Wr_En      <= 1'b0;
      Wr_Addr    <= '0;
      Wr_Data    <= '0;
      Core_Rst_N <= 1'b1;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
    end else begin
      state      <= state_nx;
      byte_idx   <= byte_idx_nx;
      buf_q      <= buf_nx;
      addr       <= addr_nx;
      cnt        <= cnt_nx;
      word_cnt   <= word_cnt_nx;
      Byte_Ready <= ready_nx;
      Wr_En      <= wr_en_nx;
      Wr_Addr    <= wr_addr_nx;
      Wr_Data    <= wr_data_nx;
      Core_Rst_N <= core_rst_n_nx;
      Busy       <= busy_nx;
      Done       <= done_nx;
      Err        <= err_nx;
    end
  end

  // Every output is computed one cycle ahead so the registered copy lines up with the state.
  always_comb begin
    state_nx      = state;
    byte_idx_nx   = byte_idx;
    buf_nx        = buf_q;
    addr_nx       = addr;
    cnt_nx        = cnt;
    word_cnt_nx   = word_cnt;
    wr_en_nx      = 1'b0;
    wr_addr_nx    = Wr_Addr;
    wr_data_nx    = Wr_Data;
    core_rst_n_nx = Core_Rst_N;
    busy_nx       = Busy;
    done_nx       = 1'b0;
    err_nx        = Err;

    case (state)
      S_IDLE: begin
        if (Start) begin
          cnt_nx      = cnt_clamped;
          err_nx      = 1'b0;
          word_cnt_nx = '0;
          if (cnt_clamped == 7'd0) begin
            state_nx      = S_DONE;
            done_nx       = 1'b1;
            busy_nx       = 1'b0;
            core_rst_n_nx = 1'b1;
          end else begin
            state_nx      = S_RECV;
            addr_nx       = '0;
            wr_addr_nx    = '0;
            byte_idx_nx   = '0;
            busy_nx       = 1'b1;
            core_rst_n_nx = 1'b0;
          end
        end
      end

      S_RECV: begin
        if (Byte_Valid && Byte_Ready) begin
          if (byte_idx == 3'd4) begin
            byte_idx_nx = '0;
            // A set top bit on the last byte marks a corrupt word; drop it and resync.
            if (Byte_Data[7]) begin
              err_nx = 1'b1;
            end else begin
              state_nx   = S_WRITE;
              wr_en_nx   = 1'b1;
              wr_addr_nx = addr;
              wr_data_nx = IW'({Byte_Data[6:0], buf_q});
            end
          end else begin
            buf_nx[{byte_idx[1:0], 3'b000} +: 8] = Byte_Data;
            byte_idx_nx = byte_idx + 3'd1;
          end
        end
      end

      S_WRITE: begin
        addr_nx     = addr + AW'(1);
        word_cnt_nx = word_cnt + 7'd1;
        if (word_cnt + 7'd1 == cnt) begin
          state_nx      = S_DONE;
          done_nx       = 1'b1;
          busy_nx       = 1'b0;
          core_rst_n_nx = 1'b1;
        end else begin
          state_nx = S_RECV;
        end
      end

      S_DONE: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase

    ready_nx = (state_nx == S_RECV);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected cache writes,
// a negedge monitor pops and compares them whenever Wr_En is seen.
module tb_imem_loader;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [6:0]  Word_Count;
  logic        Byte_Valid;
  logic [7:0]  Byte_Data;
  logic        Byte_Ready;
  logic        Wr_En;
  logic [5:0]  Wr_Addr;
  logic [38:0] Wr_Data;
  logic        Core_Rst_N;
  logic        Busy;
  logic        Done;
  logic        Err;

  imem_loader dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Start      (Start),
    .Word_Count (Word_Count),
    .Byte_Valid (Byte_Valid),
    .Byte_Data  (Byte_Data),
    .Byte_Ready (Byte_Ready),
    .Wr_En      (Wr_En),
    .Wr_Addr    (Wr_Addr),
    .Wr_Data    (Wr_Data),
    .Core_Rst_N (Core_Rst_N),
    .Busy       (Busy),
    .Done       (Done),
    .Err        (Err)
  );

  typedef struct packed {
    logic [5:0]  addr;
    logic [38:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks      = 0;
  int  failures    = 0;
  int  write_count = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d writes still expected", exp_q.size());
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (Rst && Wr_En) begin
      wr_t e;
      write_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write: addr %0h data %0h, no write expected", Wr_Addr, Wr_Data);
      end else begin
        e = exp_q.pop_front();
        check_output("wr_addr", 64'(Wr_Addr), 64'(e.addr));
        check_output("wr_data", 64'(Wr_Data), 64'(e.data));
      end
    end
  end

  task automatic expect_write(input logic [5:0] a, input logic [38:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic apply_start(input logic [6:0] n);
    @(posedge Clk); #1;
    Start      = 1'b1;
    Word_Count = n;
    @(posedge Clk); #1;
    Start      = 1'b0;
  endtask

  // Returns one tick after the posedge on which the byte transferred.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int   gap;
    logic accepted;
    logic ready_now;
    gap        = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    Byte_Valid = 1'b0;
    repeat (gap) begin
      @(posedge Clk); #1;
    end
    Byte_Valid = 1'b1;
    Byte_Data  = b;
    accepted   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      ready_now = Byte_Ready;
      @(posedge Clk); #1;
      if (ready_now) begin
        accepted = 1'b1;
        break;
      end
    end
    Byte_Valid = 1'b0;
    check_output("byte_accepted", 64'(accepted), 64'd1);
  endtask

  task automatic send_word(input logic [38:0] w, input logic bad, input int max_gap);
    send_byte(w[7:0],   max_gap);
    send_byte(w[15:8],  max_gap);
    send_byte(w[23:16], max_gap);
    send_byte(w[31:24], max_gap);
    send_byte({bad, w[38:32]}, max_gap);
  endtask

  task automatic wait_done(input int limit);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge Clk);
      if (Done) begin
        seen = 1'b1;
        break;
      end
    end
    check_output("done_pulse", 64'(seen), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_byte_ready"}, 64'(Byte_Ready), 64'd0);
    check_output({tag, "_wr_en"},      64'(Wr_En),      64'd0);
    check_output({tag, "_wr_addr"},    64'(Wr_Addr),    64'd0);
    check_output({tag, "_wr_data"},    64'(Wr_Data),    64'd0);
    check_output({tag, "_core_rst_n"}, 64'(Core_Rst_N), 64'd1);
    check_output({tag, "_busy"},       64'(Busy),       64'd0);
    check_output({tag, "_done"},       64'(Done),       64'd0);
    check_output({tag, "_err"},        64'(Err),        64'd0);
  endtask

  initial begin
    int base;
    int activity;
    logic [38:0] w;

    Rst        = 1'b1;
    Start      = 1'b0;
    Word_Count = '0;
    Byte_Valid = 1'b0;
    Byte_Data  = '0;

    // Asynchronous reset before any clock edge, then ten idle cycles.
    #2 Rst = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
    activity = 0;
    repeat (10) begin
      @(negedge Clk);
      if (Byte_Ready || Wr_En || Busy || Done) activity++;
    end
    check_output("idle_activity", 64'(activity), 64'd0);

    // Single word with exact latency checks.
    $display("[TB] single word");
    base = write_count;
    apply_start(7'd1);
    @(negedge Clk);
    check_output("sw_busy",       64'(Busy),       64'd1);
    check_output("sw_core_rst_n", 64'(Core_Rst_N), 64'd0);
    check_output("sw_byte_ready", 64'(Byte_Ready), 64'd1);
    expect_write(6'd0, 39'h45_1234_5678);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    send_byte(8'h45, 0);
    @(negedge Clk);
    check_output("sw_wr_en_n1",      64'(Wr_En),      64'd1);
    check_output("sw_core_rst_n_n1", 64'(Core_Rst_N), 64'd0);
    check_output("sw_done_n1",       64'(Done),       64'd0);
    check_output("sw_ready_n1",      64'(Byte_Ready), 64'd0);
    @(negedge Clk);
    check_output("sw_done_n2",       64'(Done),       64'd1);
    check_output("sw_core_rst_n_n2", 64'(Core_Rst_N), 64'd1);
    check_output("sw_busy_n2",       64'(Busy),       64'd0);
    @(negedge Clk);
    check_output("sw_done_pulse_end", 64'(Done), 64'd0);
    check_output("sw_writes", 64'(write_count - base), 64'd1);
    check_output("sw_err", 64'(Err), 64'd0);

    // Three words with random source gaps.
    $display("[TB] backpressure");
    base = write_count;
    apply_start(7'd3);
    expect_write(6'd0, 39'h01_0203_0405);
    send_word(39'h01_0203_0405, 1'b0, 3);
    expect_write(6'd1, 39'h7F_FFFF_FFFF);
    send_word(39'h7F_FFFF_FFFF, 1'b0, 3);
    expect_write(6'd2, 39'h2A_DEAD_BEEF);
    send_word(39'h2A_DEAD_BEEF, 1'b0, 3);
    wait_done(10);
    check_output("bp_writes", 64'(write_count - base), 64'd3);
    check_output("bp_sb_empty", 64'(exp_q.size()), 64'd0);

    // Framing error on the first word; two good words follow.
    $display("[TB] framing error");
    base = write_count;
    apply_start(7'd2);
    send_word(39'h00_2233_4455, 1'b1, 0);
    @(negedge Clk);
    check_output("fe_err",   64'(Err),        64'd1);
    check_output("fe_wr_en", 64'(Wr_En),      64'd0);
    check_output("fe_ready", 64'(Byte_Ready), 64'd1);
    expect_write(6'd0, 39'h3C_CAFE_F00D);
    send_word(39'h3C_CAFE_F00D, 1'b0, 1);
    expect_write(6'd1, 39'h55_0BAD_BEEF);
    send_word(39'h55_0BAD_BEEF, 1'b0, 1);
    wait_done(10);
    check_output("fe_writes", 64'(write_count - base), 64'd2);
    check_output("fe_err_sticky", 64'(Err), 64'd1);

    // Zero-length load: Done the cycle after Start, Err cleared, no writes.
    $display("[TB] zero words");
    base = write_count;
    apply_start(7'd0);
    @(negedge Clk);
    check_output("z_done",       64'(Done),       64'd1);
    check_output("z_busy",       64'(Busy),       64'd0);
    check_output("z_core_rst_n", 64'(Core_Rst_N), 64'd1);
    check_output("z_err_clear",  64'(Err),        64'd0);
    repeat (3) @(negedge Clk);
    check_output("z_writes", 64'(write_count - base), 64'd0);

    // Oversized request clamps to a full 64-entry fill.
    $display("[TB] clamp to 64");
    base = write_count;
    apply_start(7'd100);
    for (int i = 0; i < 64; i++) begin
      w = {7'(i) ^ 7'h2B, 32'hC0DE_0000 + 32'(i) * 32'h0001_0203};
      expect_write(6'(i), w);
      send_word(w, 1'b0, 0);
    end
    wait_done(10);
    check_output("cl_writes", 64'(write_count - base), 64'd64);
    check_output("cl_sb_empty", 64'(exp_q.size()), 64'd0);

    // Start during RECV is ignored; reset after two of four words abandons the load.
    $display("[TB] reset mid-load");
    base = write_count;
    apply_start(7'd4);
    expect_write(6'd0, 39'h12_3456_789A);
    send_word(39'h12_3456_789A, 1'b0, 0);
    apply_start(7'd1);
    expect_write(6'd1, 39'h6E_A5A5_5A5A);
    send_word(39'h6E_A5A5_5A5A, 1'b0, 0);
    repeat (2) @(negedge Clk);
    @(posedge Clk);
    #3 Rst = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge Clk);
    #1 Rst = 1'b1;
    check_output("mr_writes", 64'(write_count - base), 64'd2);
    check_output("mr_sb_empty", 64'(exp_q.size()), 64'd0);
    apply_start(7'd1);
    expect_write(6'd0, 39'h01_FEED_FACE);
    send_word(39'h01_FEED_FACE, 1'b0, 0);
    wait_done(10);
    check_output("mr_restart_sb_empty", 64'(exp_q.size()), 64'd0);

    repeat (3) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
